// File: rtl/imem_loader_pkg.sv
// Shared state encoding and framing constants for the instruction-memory boot loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_CHK   = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int HDR_BYTES      = 4;

endpackage

// File: rtl/imem_byte_packer.sv
// Little-endian byte-to-word shifter shared by the header and data phases.
module imem_byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr_i,
    input  logic        shift_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic [1:0]  byte_cnt_o,
    output logic        word_full_o
);

    logic [31:0] word_q, word_d;
    logic [1:0]  cnt_q, cnt_d;

    // New bytes enter at the top, so after four shifts byte 0 sits in [7:0].
    assign word_d      = {byte_i, word_q[31:8]};
    assign cnt_d       = cnt_q + 2'd1;
    assign word_o      = word_d;
    assign byte_cnt_o  = cnt_q;
    assign word_full_o = shift_i && (cnt_q == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else if (clr_i) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else if (shift_i) begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: header word count, then N little-endian words written to instruction RAM.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int MAX_WORDS = 2 ** ADDR_WIDTH;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   idx_q, idx_d, idx_inc;
    logic [ADDR_WIDTH:0]   n_q, n_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [31:0]           packed_word;
    logic [1:0]            byte_cnt;
    logic                  word_full;
    logic                  take;
    logic                  restart;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            xor_q, xor_d;
`endif

    assign restart = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
    assign take    = rx_valid && rx_ready && (state_q == S_HDR || state_q == S_DATA);
    assign idx_inc = idx_q + (ADDR_WIDTH + 1)'(1);

    imem_byte_packer u_packer (
        .clk         (clk),
        .reset       (reset),
        .clr_i       (restart),
        .shift_i     (take),
        .byte_i      (rx_data),
        .word_o      (packed_word),
        .byte_cnt_o  (byte_cnt),
        .word_full_o (word_full)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        n_d     = n_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef LOADER_CHECKSUM_EN
        xor_d   = xor_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_HDR;
                    idx_d   = '0;
`ifdef LOADER_CHECKSUM_EN
                    xor_d   = '0;
`endif
                end
            end
            S_HDR: begin
                if (word_full) begin
                    if (packed_word == '0) begin
                        state_d = S_DONE;
                    end else if (packed_word > 32'(MAX_WORDS)) begin
                        state_d = S_ERR;
                    end else begin
                        n_d     = packed_word[ADDR_WIDTH:0];
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
`ifdef LOADER_CHECKSUM_EN
                if (take) xor_d = xor_q ^ rx_data;
`endif
                // Address/data are registered here so they are stable in WRITE and hold afterwards.
                if (word_full) begin
                    addr_d  = idx_q[ADDR_WIDTH-1:0];
                    wdata_d = packed_word;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                idx_d = idx_inc;
                if (idx_inc == n_q) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = S_CHK;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_DATA;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                if (rx_valid) state_d = (rx_data == xor_q) ? S_DONE : S_ERR;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            n_q     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            xor_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
            xor_q   <= xor_d;
`endif
        end
    end

`ifdef LOADER_CHECKSUM_EN
    assign rx_ready = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CHK);
    assign busy     = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_WRITE) ||
                      (state_q == S_CHK);
`else
    assign rx_ready = (state_q == S_HDR) || (state_q == S_DATA);
    assign busy     = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_WRITE);
`endif
    assign mem_we    = (state_q == S_WRITE);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign done      = (state_q == S_DONE);
    assign error     = (state_q == S_ERR);
    assign cpu_hold  = (state_q != S_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: expected RAM writes are queued at stimulus time
// and matched by an independent write monitor.
module tb_imem_loader;

    localparam int AW   = 8;
    localparam int MAXW = 2 ** AW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          rx_ready, mem_we, cpu_hold, busy, done, error;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;

    imem_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    int          checks = 0;
    int          errors = 0;
    wr_t         exp_q[$];
    logic [7:0]  tx_q[$];
    logic [31:0] tb_ram [MAXW];
    logic        hs_q = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) hs_q <= rx_valid && rx_ready;

    always @(negedge clk) begin
        if (!reset && mem_we) begin
            chk("we_follows_last_byte", 32'(hs_q), 32'd1);
            chk("rx_ready_low_in_write", 32'(rx_ready), 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_addr, mem_wdata);
            end else begin
                chk("wr_addr", 32'(mem_addr), 32'(exp_q[0].addr));
                chk("wr_data", mem_wdata, exp_q[0].data);
                void'(exp_q.pop_front());
            end
            tb_ram[mem_addr] <= mem_wdata;
        end
    end

    // ---------------- stimulus helpers (all start/end just after a negedge) ----------------
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        n = 0;
        while (!rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) chk("rx_ready_timeout", 32'(rx_ready), 32'd1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_outcome(input bit exp_ok);
        int n = 0;
        while (!(done || error) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("outcome_done", 32'(done), 32'(exp_ok));
        chk("outcome_error", 32'(error), 32'(!exp_ok));
        chk("outcome_cpu_hold", 32'(cpu_hold), 32'(!exp_ok));
        chk("outcome_busy", 32'(busy), 32'd0);
        chk("writes_drained", 32'(exp_q.size()), 32'd0);
    endtask

    // One complete image. Data bytes come from tx_q if preloaded, else random.
    task automatic run_load(input int unsigned n, input int maxgap, input bit bad_chk, input bit mid_start);
        logic [31:0] hdr;
        logic [7:0]  x;
        wr_t         w;
        hdr = n;
        x   = 8'h00;
        if (tx_q.size() == 0 && n <= MAXW)
            for (int i = 0; i < 4 * int'(n); i++) tx_q.push_back(8'($urandom));
        pulse_start();
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("flags_cleared", 32'({done, error}), 32'd0);
        for (int i = 0; i < 4; i++) send_byte(hdr[8*i +: 8], int'($urandom_range(0, maxgap)));
        if (n == 0 || n > MAXW) begin
            chk("hdr_done_now", 32'(done), 32'(n == 0));
            chk("hdr_error_now", 32'(error), 32'(n > MAXW));
            chk("hdr_rx_ready_off", 32'(rx_ready), 32'd0);
            wait_outcome(n == 0);
            tx_q.delete();
            return;
        end
        for (int i = 0; i < int'(n); i++) begin
            w.addr = 8'(i);
            w.data = {tx_q[4*i+3], tx_q[4*i+2], tx_q[4*i+1], tx_q[4*i]};
            exp_q.push_back(w);
        end
        for (int i = 0; i < 4 * int'(n); i++) begin
            x ^= tx_q[i];
            send_byte(tx_q[i], int'($urandom_range(0, maxgap)));
            if (mid_start && i == 1) pulse_start();
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(x ^ {7'd0, bad_chk}, 0);
        wait_outcome(!bad_chk);
`else
        wait_outcome(1'b1);
`endif
        tx_q.delete();
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_ctl"}, 32'({rx_ready, mem_we, busy, done, error, cpu_hold}), 32'b000001);
        chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_wdata"}, mem_wdata, 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        repeat (3) @(negedge clk);
        chk_reset_values("reset");
        reset = 1'b0;
        @(negedge clk);

        // Directed two-word image
        tx_q = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_load(2, 0, 1'b0, 1'b0);
        chk("ram0", tb_ram[0], 32'h12345678);
        chk("ram1", tb_ram[1], 32'hDEADBEEF);

        // Empty image, then oversize header
        run_load(0, 2, 1'b0, 1'b0);
        run_load(MAXW + 1, 1, 1'b0, 1'b0);

        // Single word with idle gaps, and a start pulse mid-load that must be ignored
        run_load(1, 5, 1'b0, 1'b1);

        // Reset after two of four data bytes
        pulse_start();
        for (int i = 0; i < 4; i++) send_byte((i == 0) ? 8'h01 : 8'h00, 0);
        send_byte(8'hA5, 1);
        send_byte(8'h5A, 0);
        reset = 1'b1;
        #1;
        chk_reset_values("midload_reset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tx_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_load(1, 2, 1'b0, 1'b0);
        chk("reload_ram0", tb_ram[0], 32'h44332211);

`ifdef LOADER_CHECKSUM_EN
        tx_q = '{8'h04, 8'h03, 8'h02, 8'h01};
        run_load(1, 0, 1'b0, 1'b0);
        tx_q = '{8'h04, 8'h03, 8'h02, 8'h01};
        run_load(1, 0, 1'b1, 1'b0);
`endif

        // Random images, including restarts from both DONE and ERR
        for (int r = 0; r < 8; r++)
            run_load($urandom_range(1, 6), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);

        // Full-capacity image
        run_load(MAXW, 0, 1'b0, 1'b0);
        chk("full_last_addr", 32'(mem_addr), 32'(MAXW - 1));

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
